pr_pp_fwd: RTL and testbench

Parametrised PageRank processing pipeline. Scatter mode multiplies the source attribute by the source out-degree factor to emit updates. Gather mode accumulates incoming updates into the partition buffer (URAM). Adds read-after-write forwarding in gather, so back-to-back updates to the same destination accumulate correctly. Sits between the edge/update streams and the partition buffer in each processing core.

---
 rtl/pr_pp_fwd_if.sv | 39 +++
 rtl/pr_pp_fwd.sv | 168 ++++++++++++++++
 tb/tb_pr_pp_fwd.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_pp_fwd_if.sv
// rtl/pr_pp_fwd_if.sv - stream and partition-buffer port bundle for pr_pp_fwd
// master drives the edge/update streams and buffer read side; slave is the pipeline.
interface pr_pp_fwd_if #(
  parameter int URAM_DATA_W = 32,
  parameter int DEST_W      = 32,
  parameter int EDGE_W      = 64,
  parameter int PAR_SIZE_W  = 10,
  parameter int CNT_W       = 16
);
  logic [1:0]                  control;
  logic [URAM_DATA_W-1:0]      buffer_Din;
  logic                        buffer_Din_valid;
  logic [URAM_DATA_W+DEST_W-1:0] Update_input_word;
  logic                        Update_input_valid;
  logic [URAM_DATA_W-1:0]      source_outcome;
  logic [EDGE_W-1:0]           Edge_input_word;
  logic                        Edge_input_valid;
  logic [URAM_DATA_W-1:0]      buffer_Dout;
  logic [PAR_SIZE_W-1:0]       buffer_Dout_Addr;
  logic                        buffer_Dout_valid;
  logic [URAM_DATA_W+DEST_W-1:0] output_word;
  logic                        output_valid;
  logic                        par_active;
  logic [CNT_W-1:0]            upd_count;

  modport slave (
    input  control, buffer_Din, buffer_Din_valid, Update_input_word, Update_input_valid,
           source_outcome, Edge_input_word, Edge_input_valid,
    output buffer_Dout, buffer_Dout_Addr, buffer_Dout_valid, output_word, output_valid,
           par_active, upd_count
  );

  modport master (
    output control, buffer_Din, buffer_Din_valid, Update_input_word, Update_input_valid,
           source_outcome, Edge_input_word, Edge_input_valid,
    input  buffer_Dout, buffer_Dout_Addr, buffer_Dout_valid, output_word, output_valid,
           par_active, upd_count
  );
endinterface

// File: rtl/pr_pp_fwd.sv
// rtl/pr_pp_fwd.sv - PageRank scatter/gather pipeline with gather read-after-write forwarding
// Define PR_PP_FWD_EN to build the forwarding network and post-commit write history.
module pr_pp_fwd #(
  parameter int PIPE_DEPTH  = 5,
  parameter int URAM_DATA_W = 32,
  parameter int DEST_W      = 32,
  parameter int EDGE_W      = 64,
  parameter int PAR_SIZE_W  = 10,
  parameter int FWD_DEPTH   = 2,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pr_pp_fwd_if.slave    bus
);
  localparam int UW = URAM_DATA_W + DEST_W;

  // S0: registered input stage
  logic                   e_v_q;
  logic [EDGE_W-1:0]      e_word_q;
  logic                   u_v_q;
  logic [UW-1:0]          u_word_q;
  logic [URAM_DATA_W-1:0] src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_v_q    <= 1'b0;
      e_word_q <= '0;
      u_v_q    <= 1'b0;
      u_word_q <= '0;
      src_q    <= '0;
    end else begin
      e_v_q    <= bus.Edge_input_valid;
      e_word_q <= bus.Edge_input_word;
      u_v_q    <= bus.Update_input_valid;
      u_word_q <= bus.Update_input_word;
      src_q    <= bus.source_outcome;
    end
  end

  logic [DEST_W-1:0]      e_dest;
  logic [DEST_W-1:0]      u_dest;
  logic [URAM_DATA_W-1:0] u_val;
  logic [PAR_SIZE_W-1:0]  s0_addr;
  logic                   sc_acc;
  logic                   ga_acc;

  assign e_dest  = e_word_q[EDGE_W-1 -: DEST_W];
  assign u_dest  = u_word_q[DEST_W-1:0];
  assign u_val   = u_word_q[UW-1 -: URAM_DATA_W];
  assign s0_addr = u_dest[PAR_SIZE_W-1:0];
  assign sc_acc  = e_v_q & bus.buffer_Din_valid & (bus.control == 2'd1);
  assign ga_acc  = u_v_q & bus.buffer_Din_valid & (bus.control == 2'd2);

  // Stages 1..PIPE_DEPTH; st_g marks a gather item so mode survives control changes
  logic [PIPE_DEPTH:1]    st_v_q,  st_v_d;
  logic [PIPE_DEPTH:1]    st_g_q,  st_g_d;
  logic [URAM_DATA_W-1:0] st_val_q  [1:PIPE_DEPTH];
  logic [URAM_DATA_W-1:0] st_val_d  [1:PIPE_DEPTH];
  logic [DEST_W-1:0]      st_dest_q [1:PIPE_DEPTH];
  logic [DEST_W-1:0]      st_dest_d [1:PIPE_DEPTH];

  logic [URAM_DATA_W-1:0] operand;

`ifdef PR_PP_FWD_EN
  logic [FWD_DEPTH:1]     h_v_q;
  logic [PAR_SIZE_W-1:0]  h_addr_q [1:FWD_DEPTH];
  logic [URAM_DATA_W-1:0] h_val_q  [1:FWD_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v_q <= '0;
      for (int i = 1; i <= FWD_DEPTH; i++) begin
        h_addr_q[i] <= '0;
        h_val_q[i]  <= '0;
      end
    end else begin
      h_v_q[1]    <= st_v_q[PIPE_DEPTH] & st_g_q[PIPE_DEPTH];
      h_addr_q[1] <= st_dest_q[PIPE_DEPTH][PAR_SIZE_W-1:0];
      h_val_q[1]  <= st_val_q[PIPE_DEPTH];
      for (int i = 2; i <= FWD_DEPTH; i++) begin
        h_v_q[i]    <= h_v_q[i-1];
        h_addr_q[i] <= h_addr_q[i-1];
        h_val_q[i]  <= h_val_q[i-1];
      end
    end
  end

  // Oldest candidates are applied first so the youngest match overrides them.
  always_comb begin
    operand = bus.buffer_Din;
    for (int i = FWD_DEPTH; i >= 1; i--) begin
      if (h_v_q[i] && (h_addr_q[i] == s0_addr)) operand = h_val_q[i];
    end
    for (int j = PIPE_DEPTH; j >= 1; j--) begin
      if (st_v_q[j] && st_g_q[j] && (st_dest_q[j][PAR_SIZE_W-1:0] == s0_addr))
        operand = st_val_q[j];
    end
  end
`else
  assign operand = bus.buffer_Din;
`endif

  always_comb begin
    st_v_d    = st_v_q;
    st_g_d    = st_g_q;
    st_val_d  = st_val_q;
    st_dest_d = st_dest_q;
    st_v_d[1] = sc_acc | ga_acc;
    if (sc_acc) begin
      st_g_d[1]    = 1'b0;
      st_val_d[1]  = src_q * bus.buffer_Din;
      st_dest_d[1] = e_dest;
    end else if (ga_acc) begin
      st_g_d[1]    = 1'b1;
      st_val_d[1]  = u_val + operand;
      st_dest_d[1] = u_dest;
    end
    // Bubbles advance their valid only; data registers keep their last item.
    for (int j = 2; j <= PIPE_DEPTH; j++) begin
      st_v_d[j] = st_v_q[j-1];
      if (st_v_q[j-1]) begin
        st_g_d[j]    = st_g_q[j-1];
        st_val_d[j]  = st_val_q[j-1];
        st_dest_d[j] = st_dest_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v_q <= '0;
      st_g_q <= '0;
      for (int j = 1; j <= PIPE_DEPTH; j++) begin
        st_val_q[j]  <= '0;
        st_dest_q[j] <= '0;
      end
    end else begin
      st_v_q    <= st_v_d;
      st_g_q    <= st_g_d;
      st_val_q  <= st_val_d;
      st_dest_q <= st_dest_d;
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.control == 2'd0)
      cnt_d = '0;
    else if (ga_acc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.output_word       = {st_val_q[PIPE_DEPTH], st_dest_q[PIPE_DEPTH]};
  assign bus.output_valid      = st_v_q[PIPE_DEPTH] & ~st_g_q[PIPE_DEPTH];
  assign bus.buffer_Dout       = st_val_q[PIPE_DEPTH];
  assign bus.buffer_Dout_Addr  = st_dest_q[PIPE_DEPTH][PAR_SIZE_W-1:0];
  assign bus.buffer_Dout_valid = st_v_q[PIPE_DEPTH] & st_g_q[PIPE_DEPTH];
  assign bus.par_active        = sc_acc | ga_acc | (|st_v_q);
  assign bus.upd_count         = cnt_q;
endmodule

// File: tb/tb_pr_pp_fwd.sv
// tb/tb_pr_pp_fwd.sv - self-checking bench for pr_pp_fwd (directed table, corner sequences, random vs model)
module tb_pr_pp_fwd;
  localparam int P = 5, F = 2, W = 32, D = 32, E = 64, A = 10, C = 16;
  localparam int N = 800;
  localparam int NT = N + 2 * P + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pr_pp_fwd_if #(.URAM_DATA_W(W), .DEST_W(D), .EDGE_W(E), .PAR_SIZE_W(A), .CNT_W(C)) bus ();

  pr_pp_fwd #(.PIPE_DEPTH(P), .URAM_DATA_W(W), .DEST_W(D), .EDGE_W(E), .PAR_SIZE_W(A),
              .FWD_DEPTH(F), .CNT_W(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic bdv, input logic [W-1:0] din);
    bus.control = ctrl;
    bus.buffer_Din_valid = bdv;
    bus.buffer_Din = din;
  endtask

  task automatic drive_edge(input logic v, input logic [W-1:0] src, input logic [D-1:0] dest);
    bus.Edge_input_valid = v;
    bus.source_outcome = src;
    bus.Edge_input_word = {dest, ~dest};
  endtask

  task automatic drive_upd(input logic v, input logic [W-1:0] val, input logic [D-1:0] dest);
    bus.Update_input_valid = v;
    bus.Update_input_word = {val, dest};
  endtask

  task automatic do_reset();
    drive(2'd0, 1'b0, '0);
    drive_edge(1'b0, '0, '0);
    drive_upd(1'b0, '0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string          name;
    logic [1:0]     ctrl;
    logic           bdv;
    logic           ev;
    logic           uv;
    logic [W-1:0]   src;
    logic [W-1:0]   din;
    logic [W-1:0]   uval;
    logic [D-1:0]   dest;
    logic           exp_ov;
    logic           exp_wv;
    logic [W-1:0]   exp_val;
    logic [C-1:0]   exp_cnt;
  } vec_t;

  vec_t vt[8];

  typedef struct {
    int           c;
    logic [A-1:0] a;
    logic [W-1:0] s;
  } gh_t;

  logic           e_sv  [NT];
  logic [W+D-1:0] e_sw  [NT];
  logic           e_wv  [NT];
  logic [W-1:0]   e_wd  [NT];
  logic [A-1:0]   e_wa  [NT];
  logic [C-1:0]   e_cnt [NT];

  logic [W-1:0] hz_exp[3];
  logic [W-1:0] hist_exp[4];

  initial begin
    vt[0] = '{"scatter",      2'd1, 1'b1, 1'b1, 1'b0, 32'd3,       32'd7,       32'd0,          32'h10,      1'b1, 1'b0, 32'd21,        16'd0};
    vt[1] = '{"gather",       2'd2, 1'b1, 1'b0, 1'b1, 32'd0,       32'd10,      32'd5,          32'd4,       1'b0, 1'b1, 32'd15,        16'd1};
    vt[2] = '{"gate_ctrl0",   2'd0, 1'b1, 1'b1, 1'b1, 32'd3,       32'd7,       32'd5,          32'd4,       1'b0, 1'b0, 32'd0,         16'd0};
    vt[3] = '{"gate_bdv",     2'd2, 1'b0, 1'b0, 1'b1, 32'd0,       32'd10,      32'd5,          32'd4,       1'b0, 1'b0, 32'd0,         16'd0};
    vt[4] = '{"gate_sc_noev", 2'd1, 1'b1, 1'b0, 1'b1, 32'd3,       32'd7,       32'd5,          32'd4,       1'b0, 1'b0, 32'd0,         16'd0};
    vt[5] = '{"gate_ctrl3",   2'd3, 1'b1, 1'b1, 1'b1, 32'd3,       32'd7,       32'd5,          32'd4,       1'b0, 1'b0, 32'd0,         16'd0};
    vt[6] = '{"scatter_wrap", 2'd1, 1'b1, 1'b1, 1'b0, 32'h10000,   32'h10001,   32'd0,          32'hABCD,    1'b1, 1'b0, 32'h00010000,  16'd0};
    vt[7] = '{"gather_wrap",  2'd2, 1'b1, 1'b0, 1'b1, 32'd0,       32'd2,       32'hFFFF_FFFF,  32'h12345,   1'b0, 1'b1, 32'd1,         16'd1};

`ifdef PR_PP_FWD_EN
    hz_exp   = '{32'd101, 32'd103, 32'd106};
    hist_exp = '{32'd51, 32'd55, 32'd63, 32'd52};
`else
    hz_exp   = '{32'd101, 32'd102, 32'd103};
    hist_exp = '{32'd51, 32'd54, 32'd58, 32'd52};
`endif

    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ov",  bus.output_valid, 1'b0);
    chk("rst_wv",  bus.buffer_Dout_valid, 1'b0);
    chk("rst_pa",  bus.par_active, 1'b0);
    chk("rst_cnt", bus.upd_count, '0);
    chk("rst_ow",  bus.output_word, '0);
    chk("rst_bd",  bus.buffer_Dout, '0);

    // Directed single-item table
    for (int k = 0; k < 8; k++) begin
      do_reset();
      for (int it = 0; it <= 7; it++) begin
        tick();
        if (it == 5) begin
          chk({vt[k].name, "_early_ov"}, bus.output_valid, 1'b0);
          chk({vt[k].name, "_early_wv"}, bus.buffer_Dout_valid, 1'b0);
        end
        if (it == 6) begin
          chk({vt[k].name, "_ov"}, bus.output_valid, vt[k].exp_ov);
          chk({vt[k].name, "_wv"}, bus.buffer_Dout_valid, vt[k].exp_wv);
          if (vt[k].exp_ov) chk({vt[k].name, "_ow"}, bus.output_word, {vt[k].exp_val, vt[k].dest});
          if (vt[k].exp_wv) begin
            chk({vt[k].name, "_bd"}, bus.buffer_Dout, vt[k].exp_val);
            chk({vt[k].name, "_ba"}, bus.buffer_Dout_Addr, vt[k].dest[A-1:0]);
          end
        end
        if (it == 7) begin
          chk({vt[k].name, "_cnt"}, bus.upd_count, vt[k].exp_cnt);
          chk({vt[k].name, "_pa_end"}, bus.par_active, 1'b0);
          chk({vt[k].name, "_ov_end"}, bus.output_valid | bus.buffer_Dout_valid, 1'b0);
        end
        if (it == 0) begin
          drive(vt[k].ctrl, 1'b0, 32'hBAD0_0000);
          drive_edge(vt[k].ev, vt[k].src, vt[k].dest);
          drive_upd(vt[k].uv, vt[k].uval, vt[k].dest);
        end else if (it == 1) begin
          drive(vt[k].ctrl, vt[k].bdv, vt[k].din);
          drive_edge(1'b0, 32'h5555_5555, 32'h77);
          drive_upd(1'b0, 32'h3333_3333, 32'h77);
          #1;
          chk({vt[k].name, "_pa_s0"}, bus.par_active, vt[k].exp_ov | vt[k].exp_wv);
        end else begin
          drive(vt[k].ctrl, 1'b0, 32'hBAD1_0000);
        end
      end
    end

    // Back-to-back same-destination hazard
    do_reset();
    for (int it = 0; it <= 10; it++) begin
      tick();
      if (it == 5) begin
        chk("hz_early_wv", bus.buffer_Dout_valid, 1'b0);
        chk("hz_cnt", bus.upd_count, 16'd3);
      end
      if (it >= 6 && it <= 8) begin
        chk($sformatf("hz_wv%0d", it - 6), bus.buffer_Dout_valid, 1'b1);
        chk($sformatf("hz_bd%0d", it - 6), bus.buffer_Dout, hz_exp[it - 6]);
        chk($sformatf("hz_ba%0d", it - 6), bus.buffer_Dout_Addr, 10'd7);
      end
      if (it == 9) chk("hz_wv_end", bus.buffer_Dout_valid, 1'b0);
      drive(2'd2, 1'b1, 32'd100);
      drive_upd(it < 3, W'(it + 1), 32'd7);
    end

    // Forwarding from write history, up to the window edge and one past it
    do_reset();
    for (int it = 0; it <= 28; it++) begin
      tick();
      if (it == 6)  chk("hist_a", {bus.buffer_Dout_valid, bus.buffer_Dout}, {1'b1, hist_exp[0]});
      if (it == 12) chk("hist_b", {bus.buffer_Dout_valid, bus.buffer_Dout}, {1'b1, hist_exp[1]});
      if (it == 19) chk("hist_c", {bus.buffer_Dout_valid, bus.buffer_Dout}, {1'b1, hist_exp[2]});
      if (it == 27) chk("hist_d", {bus.buffer_Dout_valid, bus.buffer_Dout}, {1'b1, hist_exp[3]});
      drive(2'd2, 1'b1, 32'd50);
      case (it)
        0:       drive_upd(1'b1, 32'd1, 32'h0001_0009);
        6:       drive_upd(1'b1, 32'd4, 32'h0002_0009);
        13:      drive_upd(1'b1, 32'd8, 32'h0003_0009);
        21:      drive_upd(1'b1, 32'd2, 32'h0004_0009);
        default: drive_upd(1'b0, 32'd0, 32'd0);
      endcase
    end

    // Reset while three gather items are in flight
    do_reset();
    for (int it = 0; it <= 4; it++) begin
      tick();
      drive(2'd2, 1'b1, 32'd20);
      drive_upd(it < 3, 32'd1, W'(it));
    end
    chk("mr_cnt_pre", bus.upd_count, 16'd3);
    chk("mr_pa_pre", bus.par_active, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_wv",  bus.buffer_Dout_valid, 1'b0);
    chk("mr_bd",  bus.buffer_Dout, '0);
    chk("mr_cnt", bus.upd_count, '0);
    chk("mr_pa",  bus.par_active, 1'b0);
    chk("mr_ow",  bus.output_word, '0);
    tick();
    rst_n = 1'b1;
    for (int it = 0; it < 10; it++) begin
      tick();
      chk($sformatf("mr_post_wv%0d", it), bus.buffer_Dout_valid, 1'b0);
      chk($sformatf("mr_post_pa%0d", it), bus.par_active, 1'b0);
    end

    // Mode switch: scatter item then gather item one cycle later
    do_reset();
    for (int it = 0; it <= 8; it++) begin
      tick();
      if (it == 6) begin
        chk("ms_ov", bus.output_valid, 1'b1);
        chk("ms_ow", bus.output_word, {32'd8, 32'h20});
        chk("ms_wv6", bus.buffer_Dout_valid, 1'b0);
      end
      if (it == 7) begin
        chk("ms_wv", bus.buffer_Dout_valid, 1'b1);
        chk("ms_bd", {bus.buffer_Dout, bus.buffer_Dout_Addr}, {32'd15, 10'd3});
        chk("ms_ov7", bus.output_valid, 1'b0);
      end
      drive_edge(it == 0, 32'd2, 32'h20);
      drive_upd(it == 1, 32'd9, 32'd3);
      if (it == 1)      drive(2'd1, 1'b1, 32'd4);
      else if (it == 2) drive(2'd2, 1'b1, 32'd6);
      else              drive(it == 0 ? 2'd1 : 2'd2, 1'b0, 32'd0);
    end

    // Randomised traffic against a timestamped reference model
    begin
      gh_t          ghq[$];
      logic         p_ev, p_uv;
      logic [W-1:0] p_src, p_uval;
      logic [D-1:0] p_edest, p_udest;
      logic [C-1:0] cnt;
      for (int i = 0; i < NT; i++) begin
        e_sv[i] = 1'b0; e_wv[i] = 1'b0; e_sw[i] = '0; e_wd[i] = '0; e_wa[i] = '0; e_cnt[i] = '0;
      end
      p_ev = 1'b0; p_uv = 1'b0; p_src = '0; p_uval = '0; p_edest = '0; p_udest = '0;
      cnt = '0;
      do_reset();
      for (int t = 0; t <= N + P + 1; t++) begin
        logic [1:0]   ctrl;
        logic         bdv, ev, uv, acc_g;
        logic [W-1:0] din, src, uval, op;
        logic [D-1:0] edest, udest;
        int           r;
        tick();
        chk($sformatf("rnd_ov@%0d", t), bus.output_valid, e_sv[t]);
        chk($sformatf("rnd_wv@%0d", t), bus.buffer_Dout_valid, e_wv[t]);
        if (e_sv[t]) chk($sformatf("rnd_ow@%0d", t), bus.output_word, e_sw[t]);
        if (e_wv[t]) chk($sformatf("rnd_bw@%0d", t), {bus.buffer_Dout, bus.buffer_Dout_Addr}, {e_wd[t], e_wa[t]});
        chk($sformatf("rnd_cnt@%0d", t), bus.upd_count, e_cnt[t]);

        r = $urandom_range(0, 9);
        ctrl = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
        bdv  = ($urandom_range(0, 3) != 0);
        din  = $urandom();
        acc_g = 1'b0;
        if (ctrl == 2'd1 && p_ev && bdv) begin
          e_sv[t + P] = 1'b1;
          e_sw[t + P] = {W'(64'(p_src) * 64'(din)), p_edest};
        end
        if (ctrl == 2'd2 && p_uv && bdv) begin
          op = din;
`ifdef PR_PP_FWD_EN
          for (int i = ghq.size() - 1; i >= 0; i--) begin
            if (t - ghq[i].c >= 1 && t - ghq[i].c <= P + F && ghq[i].a == p_udest[A-1:0]) begin
              op = ghq[i].s;
              break;
            end
          end
`endif
          acc_g = 1'b1;
          e_wv[t + P] = 1'b1;
          e_wd[t + P] = p_uval + op;
          e_wa[t + P] = p_udest[A-1:0];
          ghq.push_back('{t, p_udest[A-1:0], p_uval + op});
        end
        if (ctrl == 2'd0)               cnt = '0;
        else if (acc_g && cnt != '1)    cnt = cnt + 1'b1;
        e_cnt[t + 1] = cnt;

        ev    = (t < N) && ($urandom_range(0, 1) == 1);
        uv    = (t < N) && ($urandom_range(0, 1) == 1);
        src   = $urandom();
        edest = $urandom();
        uval  = $urandom();
        udest = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 3));
        drive(ctrl, bdv, din);
        drive_edge(ev, src, edest);
        drive_upd(uv, uval, udest);
        p_ev = ev; p_uv = uv; p_src = src; p_edest = edest; p_uval = uval; p_udest = udest;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
